// File: rtl/param_bank_adjuster.sv
// Bank of NUM_PARAMS editable settings; L/R keys step the setting chosen by current_mode,
// with hold-to-repeat, acceleration, clamp-or-wrap bounds and restore-default.
module param_bank_adjuster #(
    parameter int NUM_PARAMS    = 8,
    parameter int WIDTH         = 8,
    parameter int MIN_VAL       = 0,
    parameter int MAX_VAL       = 99,
    parameter int DEFAULT_VAL   = 50,
    parameter int WRAP          = 0,
    parameter int HOLD_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000,
    parameter int FAST_AFTER    = 8,
    parameter int FAST_STEP     = 5,
    localparam int MW = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        L_pulse,
    input  logic                        R_pulse,
    input  logic                        L_level,
    input  logic                        R_level,
    input  logic                        def_req,
    input  logic [MW-1:0]               current_mode,
    output logic [NUM_PARAMS*WIDTH-1:0] param_bus,
    output logic [WIDTH-1:0]            sel_value,
    output logic                        changed,
    output logic                        at_min,
    output logic                        at_max
);
    localparam int MAXC = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int RW   = (FAST_AFTER > 0) ? $clog2(FAST_AFTER + 1) : 1;
    localparam logic [CW-1:0]  HOLD_LAST = CW'(HOLD_DELAY - 1);
    localparam logic [CW-1:0]  PER_LAST  = CW'(REPEAT_PERIOD - 1);
    localparam logic [WIDTH:0] LIM_MIN   = (WIDTH+1)'(MIN_VAL);
    localparam logic [WIDTH:0] LIM_MAX   = (WIDTH+1)'(MAX_VAL);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT, FAST} state_t;

    logic [WIDTH-1:0] bank_q [NUM_PARAMS];
    state_t           state_q, state_d;
    logic             dir_q, dir_d;        // 1 = increment (R), 0 = decrement (L)
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    rep_q, rep_d;
    logic [MW-1:0]    mode_q;
    logic             changed_q;

    logic             mode_valid, do_step, step_up, abort, wr_en;
    logic [WIDTH-1:0] step_amt, new_val;

    // A step that would cross a bound saturates, or (WRAP) jumps to the opposite bound.
    function automatic logic [WIDTH-1:0] apply_step(input logic [WIDTH-1:0] v,
                                                    input logic up,
                                                    input logic [WIDTH-1:0] st);
        logic [WIDTH:0] s;
        if (up) begin
            s = {1'b0, v} + {1'b0, st};
            if (s > LIM_MAX) s = (WRAP != 0) ? LIM_MIN : LIM_MAX;
        end else begin
            if ({1'b0, v} < ({1'b0, st} + LIM_MIN)) s = (WRAP != 0) ? LIM_MAX : LIM_MIN;
            else                                    s = {1'b0, v} - {1'b0, st};
        end
        return s[WIDTH-1:0];
    endfunction

    assign mode_valid = int'(current_mode) < NUM_PARAMS;

    always_comb begin
        sel_value = '0;
        if (mode_valid) sel_value = bank_q[current_mode];
    end

    assign at_min  = ({1'b0, sel_value} == LIM_MIN);
    assign at_max  = ({1'b0, sel_value} == LIM_MAX);
    assign changed = changed_q;

    for (genvar i = 0; i < NUM_PARAMS; i++) begin : g_bus
        assign param_bus[i*WIDTH +: WIDTH] = bank_q[i];
    end

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        rep_d    = rep_q;
        do_step  = 1'b0;
        step_up  = dir_q;
        step_amt = WIDTH'(1);
        abort    = !(dir_q ? R_level : L_level) || (dir_q ? L_level : R_level) ||
                   (current_mode != mode_q) || def_req || (L_pulse && R_pulse);
        case (state_q)
            IDLE: begin
                if ((L_pulse ^ R_pulse) && !def_req) begin
                    do_step = 1'b1;
                    step_up = R_pulse;
                    dir_d   = R_pulse;
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    // the step ending the hold delay counts as the first of FAST_AFTER repeat steps
                    do_step = 1'b1;
                    cnt_d   = '0;
                    rep_d   = '0;
                    state_d = (FAST_AFTER <= 1) ? FAST : REPEAT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            REPEAT: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == PER_LAST) begin
                    do_step = 1'b1;
                    cnt_d   = '0;
                    rep_d   = rep_q + 1'b1;
                    if (int'(rep_q) + 1 >= FAST_AFTER - 1) state_d = FAST;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FAST: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == PER_LAST) begin
                    do_step  = 1'b1;
                    step_amt = WIDTH'(FAST_STEP);
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_en   = mode_valid && (def_req || do_step);
        new_val = def_req ? WIDTH'(DEFAULT_VAL) : apply_step(sel_value, step_up, step_amt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PARAMS; i++) bank_q[i] <= WIDTH'(DEFAULT_VAL);
            state_q   <= IDLE;
            dir_q     <= 1'b0;
            cnt_q     <= '0;
            rep_q     <= '0;
            mode_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            if (wr_en) bank_q[current_mode] <= new_val;
            state_q   <= state_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            rep_q     <= rep_d;
            mode_q    <= current_mode;
            changed_q <= wr_en && (new_val != sel_value);
        end
    end
endmodule

// File: tb/tb_param_bank_adjuster.sv
// Directed bench: a saturating bank (8 settings) and a wrapping bank (6 settings) with scaled timing.
module tb_param_bank_adjuster;
    logic        clk, rst_n, L_pulse, R_pulse, L_level, R_level, def_req;
    logic [2:0]  current_mode;
    logic [63:0] s_bus;
    logic [47:0] w_bus;
    logic [7:0]  s_sel, w_sel;
    logic        s_chg, s_min, s_max, w_chg, w_min, w_max;

    int n_cmp = 0;
    int n_bad = 0;
    int chg_cnt = 0;
    int c0;

    param_bank_adjuster #(.NUM_PARAMS(8), .WIDTH(8), .MIN_VAL(0), .MAX_VAL(99), .DEFAULT_VAL(50),
        .WRAP(0), .HOLD_DELAY(4), .REPEAT_PERIOD(3), .FAST_AFTER(2), .FAST_STEP(5)) u_sat (
        .clk(clk), .rst_n(rst_n), .L_pulse(L_pulse), .R_pulse(R_pulse), .L_level(L_level),
        .R_level(R_level), .def_req(def_req), .current_mode(current_mode), .param_bus(s_bus),
        .sel_value(s_sel), .changed(s_chg), .at_min(s_min), .at_max(s_max));

    param_bank_adjuster #(.NUM_PARAMS(6), .WIDTH(8), .MIN_VAL(0), .MAX_VAL(99), .DEFAULT_VAL(50),
        .WRAP(1), .HOLD_DELAY(4), .REPEAT_PERIOD(3), .FAST_AFTER(2), .FAST_STEP(5)) u_wrap (
        .clk(clk), .rst_n(rst_n), .L_pulse(L_pulse), .R_pulse(R_pulse), .L_level(L_level),
        .R_level(R_level), .def_req(def_req), .current_mode(current_mode), .param_bus(w_bus),
        .sel_value(w_sel), .changed(w_chg), .at_min(w_min), .at_max(w_max));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (s_chg === 1'b1) chg_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_r();
        R_pulse = 1'b1; tick(); R_pulse = 1'b0; tick();
    endtask

    task automatic pulse_l();
        L_pulse = 1'b1; tick(); L_pulse = 1'b0; tick();
    endtask

    function automatic logic [7:0] sf(input int i);
        return s_bus[i*8 +: 8];
    endfunction

    function automatic logic [7:0] wf(input int i);
        return w_bus[i*8 +: 8];
    endfunction

    logic [7:0] exp_seq [16] = '{51, 51, 51, 51, 52, 52, 52, 53, 53, 53, 58, 58, 58, 63, 63, 63};

    initial begin
        rst_n = 1'b0; L_pulse = 1'b0; R_pulse = 1'b0; L_level = 1'b0; R_level = 1'b0;
        def_req = 1'b0; current_mode = 3'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // reset state
        chk("rst_bus", s_bus, 64'h3232_3232_3232_3232);
        chk("rst_wbus", w_bus, 48'h3232_3232_3232);
        chk("rst_chg", s_chg, 1'b0);
        chk("rst_sel", s_sel, 8'd50);
        chk("rst_min", s_min, 1'b0);
        chk("rst_max", s_max, 1'b0);

        // three single increments on mode 0
        c0 = chg_cnt;
        pulse_r();
        pulse_r();
        R_pulse = 1'b1; tick(); R_pulse = 1'b0;
        chk("inc3_sel", s_sel, 8'd53);
        tick();
        chk("inc3_chg", chg_cnt - c0, 3);
        chk("inc3_others", s_bus[63:8], 56'h32_3232_3232_3232);

        // saturation at both bounds on mode 2
        current_mode = 3'd2;
        repeat (49) pulse_r();
        chk("sat_99", sf(2), 8'd99);
        chk("sat_atmax", s_max, 1'b1);
        c0 = chg_cnt;
        pulse_r();
        chk("sat_hi_hold", sf(2), 8'd99);
        chk("sat_hi_nochg", chg_cnt - c0, 0);
        repeat (99) pulse_l();
        chk("sat_0", sf(2), 8'd0);
        chk("sat_atmin", s_min, 1'b1);
        c0 = chg_cnt;
        pulse_l();
        chk("sat_lo_hold", sf(2), 8'd0);
        chk("sat_lo_nochg", chg_cnt - c0, 0);

        // wrapping bank, mode 1
        current_mode = 3'd1;
        repeat (49) pulse_r();
        chk("wrap_99", wf(1), 8'd99);
        pulse_r();
        chk("wrap_hi", wf(1), 8'd0);
        pulse_l();
        chk("wrap_lo", wf(1), 8'd99);
        chk("sat_side", sf(1), 8'd98);

        // out-of-range index on the 6-entry bank is ignored
        current_mode = 3'd7;
        pulse_r();
        chk("oor_sel", w_sel, 8'd0);
        chk("oor_bus", w_bus, 48'h3232_3200_6335);

        // hold with auto-repeat and acceleration on mode 3
        current_mode = 3'd3;
        R_pulse = 1'b1; R_level = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            R_pulse = 1'b0;
            chk($sformatf("hold_t%0d", k + 1), sf(3), exp_seq[k]);
        end
        chk("hold_wrap", wf(3), 8'd63);
        R_level = 1'b0;
        tick(6);
        chk("hold_release", sf(3), 8'd63);

        // mode change during REPEAT aborts without stepping either setting
        current_mode = 3'd4;
        R_pulse = 1'b1; R_level = 1'b1;
        tick(); R_pulse = 1'b0;
        tick(6);
        chk("mc_pre", sf(4), 8'd52);
        current_mode = 3'd5;
        tick(6);
        chk("mc_old", sf(4), 8'd52);
        chk("mc_new", sf(5), 8'd50);
        R_level = 1'b0;
        tick();

        // restore default on mode 3
        current_mode = 3'd3;
        def_req = 1'b1; tick(); def_req = 1'b0;
        chk("def_val", sf(3), 8'd50);
        chk("def_chg", s_chg, 1'b1);
        tick();

        // simultaneous L and R pulses
        current_mode = 3'd6;
        L_pulse = 1'b1; R_pulse = 1'b1; tick(); L_pulse = 1'b0; R_pulse = 1'b0;
        chk("lr_val", sf(6), 8'd50);
        chk("lr_chg", s_chg, 1'b0);
        tick();

        // asynchronous reset in the middle of FAST
        current_mode = 3'd0;
        R_pulse = 1'b1; R_level = 1'b1;
        tick(); R_pulse = 1'b0;
        tick(10);
        chk("fast_pre", sf(0), 8'd61);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_bus", s_bus, 64'h3232_3232_3232_3232);
        chk("arst_wbus", w_bus, 48'h3232_3232_3232);
        tick();
        rst_n = 1'b1;
        tick(10);
        chk("arst_nostep", sf(0), 8'd50);
        R_level = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
